// File: rtl/mmult_sched_pkg.sv
// Shared types for the matrix-multiply job scheduler: FSM states, completion
// status codes and the packed job descriptor carried through the FIFO.
package mmult_sched_pkg;

   localparam int SCHED_ADDR_W = 32;
   localparam int SCHED_ID_W   = 4;

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_TIMEOUT = 2'b01;

   typedef enum logic [2:0] {
      IDLE,
      LAUNCH,
      BUSY,
      REPORT,
      HALT
   } state_e;

   typedef struct packed {
      logic [SCHED_ADDR_W-1:0] a;
      logic [SCHED_ADDR_W-1:0] b;
      logic [SCHED_ADDR_W-1:0] c;
      logic [SCHED_ID_W-1:0]   id;
   } desc_t;

endpackage

// File: rtl/mmult_sched_fifo.sv
// Synchronous descriptor FIFO. ready_o is registered from the next count, so a
// push is refused whenever the FIFO is full, even if a pop happens that cycle.
module mmult_sched_fifo
   import mmult_sched_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  desc_t         push_data_i,
   input  logic          pop_i,
   output desc_t         head_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [CW-1:0] count_o,
   output logic          ready_o
);

   desc_t         mem_q [DEPTH];
   logic [PW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          ready_q;
   logic          do_push, do_pop;

   assign do_push = push_i && ready_q;
   assign do_pop  = pop_i && !empty_o;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign ready_o = ready_q;
   assign head_o  = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      if (do_push && !do_pop)
         count_d = count_q + CW'(1);
      else if (do_pop && !do_push)
         count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ready_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         ready_q <= (count_d != CW'(DEPTH));
         if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      end
   end

   // Storage needs no reset; pointers and count define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/mmult_job_sched.sv
// Job scheduler in front of the matrix-multiply accelerator: queues descriptors,
// launches one job at a time, reports one completion per job.
// Optional watchdog/HALT behaviour is enabled by defining MMULT_SCHED_TIMEOUT_EN.
module mmult_job_sched
   import mmult_sched_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int ID_W           = SCHED_ID_W,
   parameter int ADDR_W         = SCHED_ADDR_W,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              desc_valid,
   output logic              desc_ready,
   input  logic [ADDR_W-1:0] desc_a,
   input  logic [ADDR_W-1:0] desc_b,
   input  logic [ADDR_W-1:0] desc_c,
   input  logic [ID_W-1:0]   desc_id,
   output logic              acc_start,
   output logic [ADDR_W-1:0] acc_a,
   output logic [ADDR_W-1:0] acc_b,
   output logic [ADDR_W-1:0] acc_c,
   input  logic              acc_done,
   output logic              cmp_valid,
   input  logic              cmp_ready,
   output logic [ID_W-1:0]   cmp_id,
   output logic [1:0]        cmp_status,
   output logic              busy,
   output logic [15:0]       jobs_done,
   output logic              err_hang
);

   localparam int CW = $clog2(DEPTH + 1);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] acc_a_q, acc_b_q, acc_c_q;
   logic [ID_W-1:0]   id_q;
   logic [15:0]       jobs_q, jobs_d;
   logic              pop;
   logic              timeout_hit;

   desc_t             push_desc, head;
   logic              fifo_full, fifo_empty, fifo_ready;
   logic [CW-1:0]     fifo_count;
   logic              unused_fifo;

   assign push_desc = '{a: desc_a, b: desc_b, c: desc_c, id: desc_id};
   assign unused_fifo = ^{fifo_full, fifo_count};

   mmult_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (desc_valid),
      .push_data_i (push_desc),
      .pop_i       (pop),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count),
      .ready_o     (fifo_ready)
   );

`ifdef MMULT_SCHED_TIMEOUT_EN
   logic [31:0] tmo_q, tmo_d;
   logic [1:0]  status_q, status_d;
   logic        err_q;

   assign timeout_hit = (tmo_q == 32'(TIMEOUT_CYCLES - 1));
`else
   logic [31:0] unused_tmo;

   assign unused_tmo  = 32'(TIMEOUT_CYCLES);
   assign timeout_hit = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      jobs_d  = jobs_q;
`ifdef MMULT_SCHED_TIMEOUT_EN
      status_d = status_q;
      tmo_d    = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               pop     = 1'b1;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            state_d = BUSY;
`ifdef MMULT_SCHED_TIMEOUT_EN
            tmo_d = '0;
`endif
         end
         BUSY: begin
`ifdef MMULT_SCHED_TIMEOUT_EN
            tmo_d = tmo_q + 32'd1;
`endif
            // A done arriving on the timeout cycle still reports OK.
            if (acc_done) begin
               state_d = REPORT;
`ifdef MMULT_SCHED_TIMEOUT_EN
               status_d = ST_OK;
`endif
            end else if (timeout_hit) begin
               state_d = REPORT;
`ifdef MMULT_SCHED_TIMEOUT_EN
               status_d = ST_TIMEOUT;
`endif
            end
         end
         REPORT: begin
            if (cmp_ready) begin
               jobs_d  = jobs_q + 16'd1;
               state_d = IDLE;
`ifdef MMULT_SCHED_TIMEOUT_EN
               if (status_q == ST_TIMEOUT) state_d = HALT;
`endif
            end
         end
         default: state_d = state_q;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_a_q <= '0;
         acc_b_q <= '0;
         acc_c_q <= '0;
         id_q    <= '0;
         jobs_q  <= '0;
      end else begin
         state_q <= state_d;
         jobs_q  <= jobs_d;
         if (pop) begin
            acc_a_q <= head.a;
            acc_b_q <= head.b;
            acc_c_q <= head.c;
            id_q    <= head.id;
         end
      end
   end

`ifdef MMULT_SCHED_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tmo_q    <= '0;
         status_q <= ST_OK;
         err_q    <= 1'b0;
      end else begin
         tmo_q    <= tmo_d;
         status_q <= status_d;
         if (state_q == BUSY && !acc_done && timeout_hit) err_q <= 1'b1;
      end
   end

   assign cmp_status = status_q;
   assign err_hang   = err_q;
`else
   assign cmp_status = ST_OK;
   assign err_hang   = 1'b0;
`endif

   assign desc_ready = fifo_ready;
   assign acc_start  = (state_q == LAUNCH);
   assign acc_a      = acc_a_q;
   assign acc_b      = acc_b_q;
   assign acc_c      = acc_c_q;
   assign cmp_valid  = (state_q == REPORT);
   assign cmp_id     = id_q;
   assign busy       = (state_q != IDLE);
   assign jobs_done  = jobs_q;

endmodule
